pipe_stall_feeder: RTL
======================

// Module: pipe_stall_feeder
// PURPOSE
//  Upstream driver of a stall-frozen pipeline chain.
//  - Collects one frame of up to DEPTH words over a valid/ready input and buffers it.
//  - Bursts the frame back-to-back into the chain's in/stall_in/done_in inputs.
//  - Marks the last word with stall=1 and done=1, so each stage freezes on that word as it passes.
//  - Holds the end marker until the consumer acknowledges, then accepts the next frame.
// PARAMETERS
//  DATA_WIDTH  8  width of each data word
//  DEPTH       4  max words per frame / buffer entries (>=1)
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           asynchronous, active-low reset
//  s_valid     in   1           input word valid
//  s_ready     out  1           feeder accepts input word this cycle
//  s_data      in   DATA_WIDTH  input word
//  s_last      in   1           accompanying word is last of frame
//  ack         in   1           consumer done with frozen chain; release HOLD
//  pipe_data   out  DATA_WIDTH  to chain data input
//  pipe_stall  out  1           to chain stall input (freeze marker)
//  pipe_done   out  1           to chain done input
//  busy        out  1           high in SEND and HOLD
// BEHAVIOUR
//  Reset (rst=0, async)
//  - State IDLE. pipe_data=0, pipe_stall=0, pipe_done=0, busy=0.
//  - Word count and read pointer cleared. Buffer contents don't-care.
//  Handshake
//  - Input transfer occurs on a rising edge with s_valid & s_ready.
//  - s_ready = (state==IDLE), combinational from state only.
//  - pipe_* outputs are registered.
//  IDLE
//  - Each transfer writes buf[cnt], cnt++.
//  - Go to SEND when the transfer has s_last=1, or when it is the DEPTH-th word (implicit last).
//  - pipe_* hold their previous values; pipe_stall/pipe_done are 0 after reset or ack.
//  SEND (L = frame length, 1..DEPTH; N = edge accepting the last word)
//  - At edge N+1+i: pipe_data<=buf[i].
//  - pipe_stall<=pipe_done<=(i==L-1).
//  - At edge N+L: state<=HOLD.
//  - Words go out on consecutive cycles, no bubbles. s_valid ignored.
//  HOLD
//  - pipe_data holds word L-1; pipe_stall=pipe_done=1.
//  - ack=1 at an edge: state<=IDLE, pipe_stall<=0, pipe_done<=0, cnt<=0; pipe_data unchanged.
//  - The next frame may be accepted from the following edge.
//  Ignored inputs
//  - ack in IDLE/SEND has no effect.
//  - s_last with s_valid=0 has no effect.
//  Boundary conditions
//  - 1-word frame: word and marker leave together at N+1, HOLD at N+1.
//  - DEPTH words without s_last: frame closes at DEPTH; the next word starts a new frame after ack.
//  - Counters are $clog2(DEPTH+1) bits wide; they never wrap within a frame.
//  - rst mid-SEND/HOLD: immediate return to reset values; partial frame discarded.
//  System reset re-arms the downstream chain (its stall is sticky).
// TESTING
//  1. Reset then idle: 5 cycles -> s_ready=1, pipe_*=0, busy=0.
//  2. Frame 0x11,0x22,0x33 (last on 0x33)
//     -> pipe_data 0x11,0x22,0x33 on 3 consecutive edges after N.
//     -> stall/done=1 only with 0x33; busy=1; s_ready=0.
//  3. DEPTH=4, five words without s_last, s_valid held
//     -> first 4 sent, 4th marked.
//     -> 5th stalled (s_ready=0) until ack, then forms frame 2.
//  4. Single word 0xA5 with s_last -> pipe_data=0xA5, stall=done=1 at N+1; HOLD.
//  5. HOLD 10 cycles then ack -> outputs frozen until ack; next edge stall=done=0, s_ready=1.
//  6. rst=0 asynchronously mid-SEND of 4-word frame
//     -> outputs 0 without a clock edge.
//     -> after release, a new 2-word frame sends correctly.

Source files
------------

// File: rtl/pipe_stall_feeder.sv
// Buffers one frame of up to DEPTH words, then bursts it into a stall-frozen
// pipeline chain with the last word marked stall/done, holding until ack.
module pipe_stall_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  ack,
    output logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  pipe_stall,
    output logic                  pipe_done,
    output logic                  busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
    logic                  marker_q, marker_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic in_xfer;
    logic frame_end;
    logic last_rd;

    assign in_xfer   = s_valid & s_ready;
    // A frame closes on s_last or when the buffer's final entry is written.
    assign frame_end = s_last | (cnt_q == CW'(DEPTH - 1));
    assign last_rd   = (rd_ptr_q + CW'(1)) == cnt_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            pipe_data_q <= '0;
            marker_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            pipe_data_q <= pipe_data_d;
            marker_q    <= marker_d;
        end
    end

    // NOTE: the frame buffer has no reset; cnt_q decides which entries are
    // valid, so clearing the storage would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            mem_q[cnt_q[AW-1:0]] <= s_data;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_xfer && frame_end) state_d = SEND;
            SEND:    if (last_rd)              state_d = HOLD;
            HOLD:    if (ack)                  state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        pipe_data_d = pipe_data_q;
        marker_d    = marker_q;
        unique case (state_q)
            IDLE: begin
                if (in_xfer) cnt_d = cnt_q + CW'(1);
            end
            SEND: begin
                pipe_data_d = mem_q[rd_ptr_q[AW-1:0]];
                marker_d    = last_rd;
                rd_ptr_d    = rd_ptr_q + CW'(1);
            end
            HOLD: begin
                // pipe_data keeps the frozen word across the release.
                if (ack) begin
                    marker_d = 1'b0;
                    cnt_d    = '0;
                    rd_ptr_d = '0;
                end
            end
            default: begin
                cnt_d    = '0;
                rd_ptr_d = '0;
            end
        endcase
    end

    always_comb begin
        s_ready    = (state_q == IDLE);
        busy       = (state_q != IDLE);
        pipe_data  = pipe_data_q;
        pipe_stall = marker_q;
        pipe_done  = marker_q;
    end

endmodule
